// File: rtl/apb_pkg.sv
// Shared definitions for the APB master.
//   apb_mst_state_e : master FSM state encoding
//   apb_cmd_t       : registered command control fields
//   apb_rsp_t       : registered response status fields
//   AlignMask       : address bits that must be zero for a word access
package apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } apb_mst_state_e;

    typedef struct packed {
        logic write;
    } apb_cmd_t;

    typedef struct packed {
        logic err;
        logic timeout;
    } apb_rsp_t;

    localparam logic [1:0] AlignMask = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return |(addr_lsbs & AlignMask);
    endfunction

endpackage

// File: rtl/apb_master.sv
// APB master: converts one command (valid/ready) into a single APB transfer and
// returns one response (valid/ready). Misaligned commands are answered with an
// error and never reach the bus; a stalled ACCESS phase is aborted after
// TIMEOUT_CYC cycles.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_strb_i      command fields
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                response fields
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o, pstrb_o   APB request
//   prdata_i, pready_i, pslverr_i APB completion
module apb_master #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16   // 2..255
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_strb_i,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,

    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic [DATA_W-1:0]   pwdata_o,
    output logic [DATA_W/8-1:0] pstrb_o,
    input  logic [DATA_W-1:0]   prdata_i,
    input  logic                pready_i,
    input  logic                pslverr_i
);

    import apb_pkg::*;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    apb_mst_state_e      state_q, state_d;
    apb_cmd_t            cmd_q, cmd_d;
    apb_rsp_t            rsp_q, rsp_d;
    logic [7:0]          wait_q, wait_d;
    logic                ready_q, ready_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                accept;

    assign accept = cmd_valid_i & ready_q;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        rsp_d    = rsp_q;
        wait_d   = wait_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rdata_d  = rdata_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_misaligned(cmd_addr_i[1:0])) begin
                        // Answer directly; APB outputs keep their previous values.
                        state_d = StResp;
                        rsp_d   = '{err: 1'b1, timeout: 1'b0};
                        rdata_d = '0;
                    end else begin
                        state_d     = StSetup;
                        wait_d      = '0;
                        cmd_d.write = cmd_write_i;
                        paddr_d     = cmd_addr_i;
                        pwdata_d    = cmd_wdata_i;
                        pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (pready_i) begin
                    state_d = StResp;
                    rsp_d   = '{err: pslverr_i, timeout: 1'b0};
                    rdata_d = (!cmd_q.write && !pslverr_i) ? prdata_i : '0;
                end else if (wait_q == TimeoutLast) begin
                    state_d = StResp;
                    rsp_d   = '{err: 1'b1, timeout: 1'b1};
                    rdata_d = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so that cmd_ready_o is 0 while reset is asserted.
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            rsp_q    <= '0;
            wait_q   <= '0;
            ready_q  <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rsp_q    <= rsp_d;
            wait_q   <= wait_d;
            ready_q  <= ready_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cmd_ready_o   = ready_q;
    assign psel_o        = (state_q == StSetup) || (state_q == StAccess);
    assign penable_o     = (state_q == StAccess);
    assign pwrite_o      = cmd_q.write;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (ADDR_W=12, DATA_W=32, TIMEOUT_CYC=16).
// Cycle numbers are relative to the accept edge (cycle 0).
module tb_apb_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-transaction observations.
    int          setup_cyc, acc_first, acc_cnt, rsp_cyc;
    logic        psel_seen, apb_ok, rsp_stable;
    logic        got_err, got_tmo;
    logic [31:0] got_rdata;

    always #5 clk = ~clk;

    apb_master #(
        .ADDR_W      (12),
        .DATA_W      (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .cmd_strb_i    (cmd_strb),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .pstrb_o       (pstrb),
        .prdata_i      (prdata),
        .pready_i      (pready),
        .pslverr_i     (pslverr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One command; waits < 0 means pready never rises. Called at a negedge.
    task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                           input logic slverr, input int rsp_hold);
        logic [3:0] exp_strb;
        int cyc;
        exp_strb = wr ? strb : 4'h0;
        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        prdata    = rdata;
        pslverr   = slverr;
        pready    = 1'b0;
        rsp_ready = 1'b0;
        setup_cyc = -1; acc_first = -1; acc_cnt = 0; rsp_cyc = -1;
        psel_seen = 1'b0; apb_ok = 1'b1; rsp_stable = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (rsp_cyc < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            if (psel) begin
                psel_seen = 1'b1;
                if (paddr !== addr || pwrite !== wr || pwdata !== wdata || pstrb !== exp_strb)
                    apb_ok = 1'b0;
            end
            if (psel && !penable && setup_cyc < 0) setup_cyc = cyc;
            if (psel && penable) begin
                if (acc_first < 0) acc_first = cyc;
                acc_cnt++;
                pready = (waits >= 0) && (acc_cnt > waits);
            end else begin
                pready = 1'b0;
            end
            if (rsp_valid) rsp_cyc = cyc;
        end
        pready = 1'b0;
        if (rsp_cyc < 0) begin
            check_eq("rsp_timeout_bound", 0, 1);
        end else begin
            got_err   = rsp_err;
            got_tmo   = rsp_timeout;
            got_rdata = rsp_rdata;
            check_eq("psel_in_resp", {psel, penable}, 0);
            for (int h = 0; h < rsp_hold; h++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_err !== got_err || rsp_timeout !== got_tmo ||
                    rsp_rdata !== got_rdata)
                    rsp_stable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check_eq("rsp_drop", rsp_valid, 0);
        end
    endtask

    initial begin
        int guard;
        reset_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
        rsp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
        #1;
        check_eq("rst_outs", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}, 0);
        check_eq("rst_paddr", paddr, 0);
        check_eq("rst_pwdata", pwdata, 0);
        check_eq("rst_pstrb", pstrb, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", cmd_ready, 1);

        // Write, no waits.
        run_txn(1'b1, 12'h008, 32'hA5A5_0003, 4'hF, 0, 32'h0, 1'b0, 0);
        check_eq("wr_setup_cyc", setup_cyc, 1);
        check_eq("wr_access_cyc", acc_first, 2);
        check_eq("wr_access_len", acc_cnt, 1);
        check_eq("wr_rsp_cyc", rsp_cyc, 3);
        check_eq("wr_err", {got_err, got_tmo}, 0);
        check_eq("wr_rdata", got_rdata, 0);
        check_eq("wr_apb_fields", apb_ok, 1);

        // Read with three wait cycles.
        run_txn(1'b0, 12'h010, 32'h0BAD_0BAD, 4'hF, 3, 32'h1234_5678, 1'b0, 0);
        check_eq("rd_access_len", acc_cnt, 4);
        check_eq("rd_rsp_cyc", rsp_cyc, 6);
        check_eq("rd_rdata", got_rdata, 32'h1234_5678);
        check_eq("rd_err", {got_err, got_tmo}, 0);
        check_eq("rd_apb_fields", apb_ok, 1);

        // Misaligned read.
        run_txn(1'b0, 12'h006, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0, 0);
        check_eq("mis_psel", psel_seen, 0);
        check_eq("mis_rsp_cyc", rsp_cyc, 1);
        check_eq("mis_err", {got_err, got_tmo}, 2'b10);
        check_eq("mis_rdata", got_rdata, 0);

        // pready stuck low.
        run_txn(1'b0, 12'h014, 32'h0, 4'h0, -1, 32'h5555_AAAA, 1'b0, 0);
        check_eq("tmo_access_len", acc_cnt, 16);
        check_eq("tmo_rsp_cyc", rsp_cyc, 18);
        check_eq("tmo_err", {got_err, got_tmo}, 2'b11);
        check_eq("tmo_rdata", got_rdata, 0);

        // Normal read right after the timeout.
        run_txn(1'b0, 12'h020, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 0);
        check_eq("post_tmo_rsp_cyc", rsp_cyc, 3);
        check_eq("post_tmo_rdata", got_rdata, 32'hDEAD_BEEF);
        check_eq("post_tmo_err", {got_err, got_tmo}, 0);

        // Slave error on write, response back-pressured.
        run_txn(1'b1, 12'h0FC, 32'h0102_0304, 4'h5, 0, 32'h7777_7777, 1'b1, 5);
        check_eq("slv_err", {got_err, got_tmo}, 2'b10);
        check_eq("slv_rdata", got_rdata, 0);
        check_eq("slv_hold_stable", rsp_stable, 1);
        check_eq("slv_pstrb_fields", apb_ok, 1);
        pslverr = 1'b0;

        // Reset in the middle of an ACCESS phase.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040; prdata = 32'h1111_2222;
        pready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!penable && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check_eq("mid_reached_access", penable, 1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_psel", {psel, penable}, 0);
        check_eq("mid_rst_rsp", rsp_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_no_rsp", rsp_valid, 0);

        run_txn(1'b0, 12'h030, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0, 0);
        check_eq("post_rst_access_len", acc_cnt, 2);
        check_eq("post_rst_rsp_cyc", rsp_cyc, 4);
        check_eq("post_rst_rdata", got_rdata, 32'hCAFE_F00D);
        check_eq("post_rst_err", {got_err, got_tmo}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, 12, APB address width.
REQ-002 Parameter DATA_W, 32, APB data width; strobe width is DATA_W/8.
REQ-003 Parameter TIMEOUT_CYC, 16, maximum ACCESS-phase cycles before abort; legal range 2..255.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake; transfer on valid&ready.
REQ-007 cmd_write_i  in  1  1=write, 0=read.
REQ-008 cmd_addr_i  in  ADDR_W  byte address.
REQ-009 cmd_wdata_i  in  DATA_W  write data.
REQ-010 cmd_strb_i  in  DATA_W/8  write byte strobes.
REQ-011 rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
REQ-012 rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
REQ-013 rsp_err_o  out  1  slave error, misalignment or timeout.
REQ-014 rsp_timeout_o  out  1  error caused by timeout.
REQ-015 psel_o, penable_o, pwrite_o  out  1 each  APB control.
REQ-016 paddr_o  out  ADDR_W; pwdata_o  out  DATA_W; pstrb_o  out  DATA_W/8.
REQ-017 prdata_i  in  DATA_W; pready_i  in  1; pslverr_i  in  1.

Function
REQ-018 The FSM SHALL use states IDLE, SETUP, ACCESS, RESP.
REQ-019 cmd_ready_o SHALL be 1 only in IDLE; on accept, the command fields SHALL be registered.
REQ-020 If cmd_addr_i[1:0]!=0 on accept: go IDLE->RESP with rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0; no APB transfer.
REQ-021 Otherwise go IDLE->SETUP: psel_o=1, penable_o=0, for exactly one cycle.
REQ-022 SETUP->ACCESS unconditionally: psel_o=1, penable_o=1.
REQ-023 paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL be stable from SETUP through the final ACCESS cycle.
REQ-024 pstrb_o SHALL be cmd_strb for writes and all-zero for reads.
REQ-025 In ACCESS, an internal 8-bit wait counter SHALL increment each cycle pready_i=0 and SHALL clear on entering SETUP.
REQ-026 ACCESS with pready_i=1: capture prdata_i (reads only; else 0) and pslverr_i into the response, then go to RESP.
REQ-027 ACCESS with pready_i=0 and counter==TIMEOUT_CYC-1: abort; rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; go to RESP.
REQ-028 RESP: rsp_valid_o=1 with stable response fields until rsp_ready_i=1, then IDLE.
REQ-029 psel_o and penable_o SHALL be 0 in IDLE and RESP.
REQ-030 Latency SHALL be: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid_o at 2+N+1 for N wait cycles; minimum 4 cycles between accepts.
REQ-031 In IDLE, APB address, data and strobe outputs SHALL hold their last values.

Reset
REQ-032 On reset_n=0, the FSM SHALL enter IDLE immediately, even mid-transfer, with no response generated.
REQ-033 On reset, every output SHALL be 0; cmd_ready_o SHALL be 1 after deassertion.

Structure
REQ-034 A shared package apb_pkg SHALL hold the FSM state typedef (apb_mst_state_e), the command and response structs, and the alignment mask constant.
REQ-035 The design SHALL be a single module with no sub-modules; the counter SHALL be inline.

Verification
REQ-036 Write: addr 0x008, data 0xA5A5_0003, strb 0xF, pready=1 -> SETUP at cycle 1, ACCESS at 2, rsp_valid at 3, err=0, rdata=0.
REQ-037 Read: addr 0x010, pready held low 3 cycles, prdata=0x1234_5678 -> ACCESS lasts 4 cycles, rdata=0x1234_5678, err=0.
REQ-038 Misaligned read at 0x006 -> psel never asserts; rsp_valid at cycle 1 with err=1, timeout=0.
REQ-039 TIMEOUT_CYC=16, pready stuck 0 -> ACCESS lasts 16 cycles, then err=1, timeout=1; next command accepted normally.
REQ-040 pslverr=1 with pready on a write to 0x0FC -> err=1, timeout=0; rsp_ready held low 5 cycles keeps rsp_valid and fields stable.
REQ-041 Assert reset_n low during ACCESS of a read -> psel/penable drop at once, no response; a read issued after reset completes correctly.
